// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with occupancy, thresholds, sticky errors and optional FWFT read
module fifo_sync #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wa, ra;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AFULL_TH);
  assign almost_empty = count <= CW'(AEMPTY_TH);
  assign wa = wr_en && !full;
  assign ra = rd_en && !empty;
  // storage array, intentionally not reset
  always_ff @(posedge clk)
    if (!rst && wa) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wa ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr    <= ra ? rd_ptr + AW'(1) : rd_ptr;
      count     <= count + CW'(wa) - CW'(ra);
      overflow  <= overflow | (wr_en && full);
      underflow <= underflow | (rd_en && empty);
    end
  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_std
      // registered read: data lands the cycle after an accepted pop
      always_ff @(posedge clk)
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_data  <= ra ? mem[rd_ptr] : rd_data;
          rd_valid <= ra;
        end
    end
  endgenerate
endmodule
